// File: rtl/ex.sv
// Execute stage: combinational logic/shift/arith results plus a sequential
// restoring divider for DIV/DIVU that writes HI/LO and stalls upstream meanwhile.
module ex #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ALUOP_W  = 8,
    parameter int unsigned ALUSEL_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ALUOP_W-1:0]  aluop,
    input  logic [ALUSEL_W-1:0] alusel,
    input  logic [DATA_W-1:0]   reg1,
    input  logic [DATA_W-1:0]   reg2,
    input  logic [ADDR_W-1:0]   waddr_i,
    input  logic                we_i,
    input  logic                flush,
    output logic [ADDR_W-1:0]   waddr_o,
    output logic                we_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic                whilo_o,
    output logic [DATA_W-1:0]   hi_o,
    output logic [DATA_W-1:0]   lo_o,
    output logic                stallreq
);

    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam int unsigned SH_W  = $clog2(DATA_W);

    localparam logic [ALUOP_W-1:0] OP_OR   = ALUOP_W'(8'h25);
    localparam logic [ALUOP_W-1:0] OP_AND  = ALUOP_W'(8'h24);
    localparam logic [ALUOP_W-1:0] OP_XOR  = ALUOP_W'(8'h26);
    localparam logic [ALUOP_W-1:0] OP_NOR  = ALUOP_W'(8'h27);
    localparam logic [ALUOP_W-1:0] OP_SLL  = ALUOP_W'(8'h7C);
    localparam logic [ALUOP_W-1:0] OP_SRL  = ALUOP_W'(8'h02);
    localparam logic [ALUOP_W-1:0] OP_SRA  = ALUOP_W'(8'h03);
    localparam logic [ALUOP_W-1:0] OP_ADDU = ALUOP_W'(8'h21);
    localparam logic [ALUOP_W-1:0] OP_SUBU = ALUOP_W'(8'h23);
    localparam logic [ALUOP_W-1:0] OP_SLT  = ALUOP_W'(8'h2A);
    localparam logic [ALUOP_W-1:0] OP_SLTU = ALUOP_W'(8'h2B);
    localparam logic [ALUOP_W-1:0] OP_DIV  = ALUOP_W'(8'h1A);
    localparam logic [ALUOP_W-1:0] OP_DIVU = ALUOP_W'(8'h1B);

    localparam logic [ALUSEL_W-1:0] SEL_LOGIC = ALUSEL_W'(3'b001);
    localparam logic [ALUSEL_W-1:0] SEL_SHIFT = ALUSEL_W'(3'b010);
    localparam logic [ALUSEL_W-1:0] SEL_ARITH = ALUSEL_W'(3'b100);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DATA_W-1:0]   quo_q, quo_d;     // dividend shifting out, quotient shifting in
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   dvs_q, dvs_d;
    logic                neg_quo_q, neg_quo_d;
    logic                neg_rem_q, neg_rem_d;

    logic                is_div;
    logic                is_signed;
    logic [DATA_W-1:0]   abs1, abs2;
    logic [DATA_W:0]     trial;
    logic                qbit;
    logic [SH_W-1:0]     sh;
    logic [DATA_W-1:0]   alu_res;

    assign is_div    = (aluop == OP_DIV) || (aluop == OP_DIVU);
    assign is_signed = (aluop == OP_DIV);
    assign abs1      = (is_signed && reg1[DATA_W-1]) ? -reg1 : reg1;
    assign abs2      = (is_signed && reg2[DATA_W-1]) ? -reg2 : reg2;
    assign trial     = {rem_q, quo_q[DATA_W-1]};
    assign qbit      = (trial >= {1'b0, dvs_q});
    assign sh        = reg1[SH_W-1:0];

    always_comb begin
        alu_res = '0;
        unique case (alusel)
            SEL_LOGIC: begin
                case (aluop)
                    OP_OR:   alu_res = reg1 | reg2;
                    OP_AND:  alu_res = reg1 & reg2;
                    OP_XOR:  alu_res = reg1 ^ reg2;
                    OP_NOR:  alu_res = ~(reg1 | reg2);
                    default: alu_res = '0;
                endcase
            end
            SEL_SHIFT: begin
                case (aluop)
                    OP_SLL:  alu_res = reg2 << sh;
                    OP_SRL:  alu_res = reg2 >> sh;
                    OP_SRA:  alu_res = DATA_W'($signed(reg2) >>> sh);
                    default: alu_res = '0;
                endcase
            end
            SEL_ARITH: begin
                case (aluop)
                    OP_ADDU: alu_res = reg1 + reg2;
                    OP_SUBU: alu_res = reg1 - reg2;
                    OP_SLT:  alu_res = DATA_W'($signed(reg1) < $signed(reg2));
                    OP_SLTU: alu_res = DATA_W'(reg1 < reg2);
                    default: alu_res = '0;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        unique case (state_q)
            StIdle: begin
                if (is_div && !flush) begin
                    neg_quo_d = is_signed && (reg1[DATA_W-1] ^ reg2[DATA_W-1]);
                    neg_rem_d = is_signed && reg1[DATA_W-1];
                    rem_d     = '0;
                    count_d   = '0;
                    if (reg2 == '0) begin
                        quo_d   = '0;
                        dvs_d   = '0;
                        state_d = StDone;
                    end else begin
                        quo_d   = abs1;
                        dvs_d   = abs2;
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                // Losing the divide opcode mid-flight is handled like a flush.
                if (flush || !is_div) begin
                    state_d = StIdle;
                end else begin
                    rem_d   = qbit ? (trial[DATA_W-1:0] - dvs_q) : trial[DATA_W-1:0];
                    quo_d   = {quo_q[DATA_W-2:0], qbit};
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(DATA_W - 1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            count_q   <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    always_comb begin
        waddr_o  = '0;
        we_o     = 1'b0;
        wdata_o  = '0;
        whilo_o  = 1'b0;
        hi_o     = '0;
        lo_o     = '0;
        stallreq = 1'b0;
        if (!rst) begin
            waddr_o  = waddr_i;
            we_o     = we_i;
            wdata_o  = alu_res;
            stallreq = is_div && (state_q != StDone) && !flush;
            if (state_q == StDone && !flush) begin
                whilo_o = 1'b1;
                lo_o    = neg_quo_q ? -quo_q : quo_q;
                hi_o    = neg_rem_q ? -rem_q : rem_q;
            end
        end
    end

endmodule

// File: tb/tb_ex.sv
// Directed bench for the execute stage: ALU results, divider latency/results,
// flush and asynchronous reset behaviour.
module tb_ex;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1, reg2;
    logic [4:0]  waddr_i;
    logic        we_i;
    logic        flush;
    logic [4:0]  waddr_o;
    logic        we_o;
    logic [31:0] wdata_o;
    logic        whilo_o;
    logic [31:0] hi_o, lo_o;
    logic        stallreq;

    int checks = 0;
    int errors = 0;

    ex dut (
        .clk      (clk),
        .rst      (rst),
        .aluop    (aluop),
        .alusel   (alusel),
        .reg1     (reg1),
        .reg2     (reg2),
        .waddr_i  (waddr_i),
        .we_i     (we_i),
        .flush    (flush),
        .waddr_o  (waddr_o),
        .we_o     (we_o),
        .wdata_o  (wdata_o),
        .whilo_o  (whilo_o),
        .hi_o     (hi_o),
        .lo_o     (lo_o),
        .stallreq (stallreq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input string tag, input logic [7:0] op, input logic [2:0] sel,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        aluop = op; alusel = sel; reg1 = a; reg2 = b;
        #1;
        chk(tag, wdata_o, exp);
        chk({tag, "_stall"}, {31'b0, stallreq}, 32'd0);
        step();
    endtask

    // Holds a divide until stallreq drops, then checks latency and the DONE cycle.
    task automatic do_div(input string tag, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_stall,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int n;
        aluop = op; alusel = 3'b000; reg1 = a; reg2 = b;
        #1;
        n = 0;
        while (stallreq && n < 100) begin
            chk({tag, "_nowhilo"}, {31'b0, whilo_o}, 32'd0);
            n++;
            step();
        end
        chk({tag, "_stallcycles"}, n, exp_stall);
        chk({tag, "_whilo"}, {31'b0, whilo_o}, 32'd1);
        chk({tag, "_lo"}, lo_o, exp_lo);
        chk({tag, "_hi"}, hi_o, exp_hi);
        aluop = 8'h00;
        step();
        chk({tag, "_whilo_once"}, {31'b0, whilo_o}, 32'd0);
        chk({tag, "_hi_clear"}, hi_o, 32'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        aluop = 8'h25; alusel = 3'b001; reg1 = 32'hFFFF_FFFF; reg2 = 32'h1234_5678;
        waddr_i = 5'd7; we_i = 1'b1;
        #2;
        chk("rst_wdata", wdata_o, 32'd0);
        chk("rst_waddr", {27'b0, waddr_o}, 32'd0);
        chk("rst_we", {31'b0, we_o}, 32'd0);
        aluop = 8'h1A;
        #1;
        chk("rst_stall", {31'b0, stallreq}, 32'd0);
        aluop = 8'h00;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("pass_waddr", {27'b0, waddr_o}, 32'd7);
        chk("pass_we", {31'b0, we_o}, 32'd1);

        alu("or",      8'h25, 3'b001, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F);
        alu("and",     8'h24, 3'b001, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00);
        alu("xor",     8'h26, 3'b001, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F);
        alu("nor",     8'h27, 3'b001, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF);
        alu("sll",     8'h7C, 3'b010, 32'd4,         32'h0000_1234, 32'h0001_2340);
        alu("sll_amt", 8'h7C, 3'b010, 32'h0000_0024, 32'h0000_0001, 32'h0000_0010);
        alu("srl",     8'h02, 3'b010, 32'd4,         32'h8000_0000, 32'h0800_0000);
        alu("sra",     8'h03, 3'b010, 32'd4,         32'h8000_0000, 32'hF800_0000);
        alu("addu",    8'h21, 3'b100, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);
        alu("subu",    8'h23, 3'b100, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF);
        alu("slt",     8'h2A, 3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
        alu("sltu",    8'h2B, 3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
        alu("sel_mis", 8'h25, 3'b100, 32'hF0F0_0000, 32'h0000_0F0F, 32'h0000_0000);
        alu("sel_bad", 8'h21, 3'b111, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000);
        alu("op_bad",  8'h55, 3'b001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000);

        do_div("div_m7_2",   8'h1A, 32'hFFFF_FFF9, 32'd2,  33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        do_div("divu_max",   8'h1B, 32'hFFFF_FFFF, 32'h10, 33, 32'h0FFF_FFFF, 32'h0000_000F);
        do_div("div_7_m2",   8'h1A, 32'd7, 32'hFFFF_FFFE,  33, 32'hFFFF_FFFD, 32'h0000_0001);
        do_div("div_ovf",    8'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0);
        do_div("div_zero",   8'h1A, 32'd1234, 32'd0,        1, 32'd0, 32'd0);
        do_div("divu_100_7", 8'h1B, 32'd100, 32'd7,        33, 32'd14, 32'd2);

        // Flush at cycle 10 of a divide.
        aluop = 8'h1A; alusel = 3'b000; reg1 = 32'd1000; reg2 = 32'd3;
        for (int i = 0; i < 10; i++) step();
        flush = 1'b1;
        #1;
        chk("flush_stall", {31'b0, stallreq}, 32'd0);
        chk("flush_whilo", {31'b0, whilo_o}, 32'd0);
        step();
        flush = 1'b0;
        aluop = 8'h00;
        #1;
        chk("post_flush_stall", {31'b0, stallreq}, 32'd0);
        chk("post_flush_whilo", {31'b0, whilo_o}, 32'd0);
        step();
        do_div("after_flush", 8'h1B, 32'd1000, 32'd3, 33, 32'd333, 32'd1);

        // Asynchronous reset in the middle of BUSY.
        aluop = 8'h1A; alusel = 3'b000; reg1 = 32'd50; reg2 = 32'd5;
        for (int i = 0; i < 6; i++) step();
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_stall", {31'b0, stallreq}, 32'd0);
        chk("mid_rst_whilo", {31'b0, whilo_o}, 32'd0);
        chk("mid_rst_we", {31'b0, we_o}, 32'd0);
        chk("mid_rst_waddr", {27'b0, waddr_o}, 32'd0);
        aluop = 8'h00;
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_whilo", {31'b0, whilo_o}, 32'd0);
        step();
        do_div("after_rst", 8'h1A, 32'hFFFF_FFCE, 32'd5, 33, 32'hFFFF_FFF6, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
